sti_rx: RTL

Serial-to-parallel receiver for the STI link: the receive end of the serial transmitter interface. It samples the `si_data`/`si_valid` bit stream and reassembles 8/16/24/32-bit frames into the original 16-bit parallel word. It also emits each received 8-bit group as a pixel byte with an incrementing address, so a receive-side memory can be compared against the transmit-side pixel memory. It sits after the serial link on the loopback/checker side of the design.

---
 rtl/sti_rx.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sti_rx.sv
// sti_rx - serial-to-parallel receiver for the STI link.
//
// Samples the si_data/si_valid bit stream, reassembles 8/16/24/32-bit frames
// into a 16-bit parallel word and also emits every received 8-bit group as an
// addressed byte, so the receive side can rebuild the transmit pixel memory.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   cfg_length      frame length: 0=8, 1=16, 2=24, 3=32 bits
//   cfg_msb         1 = first serial bit is frame MSB, 0 = frame LSB
//   cfg_fill        24/32-bit: 1 = data in upper 16 bits, 0 = lower 16 bits
//   cfg_low         8-bit: 1 = byte goes to po_data[15:8], 0 = po_data[7:0]
//   cfg_end         1 = this frame is the last one
//   si_data/valid   serial input bit and its qualifier
//   po_data/valid   reassembled word and its one-cycle strobe
//   byte_data/addr  received byte (first bit at bit 7) and its address
//   byte_valid      one-cycle strobe for byte_data/byte_addr
//   pad_err         with po_valid: a pad bit was nonzero
//   frame_err       one-cycle pulse: frame truncated by si_valid dropping
//   rx_finish       sticky: the last frame has completed
module sti_rx (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_msb,
    input  logic        cfg_fill,
    input  logic        cfg_low,
    input  logic        cfg_end,
    input  logic        si_data,
    input  logic        si_valid,
    output logic [15:0] po_data,
    output logic        po_valid,
    output logic [7:0]  byte_data,
    output logic [7:0]  byte_addr,
    output logic        byte_valid,
    output logic        pad_err,
    output logic        frame_err,
    output logic        rx_finish
);

    typedef enum logic [1:0] {IDLE, RECV, FIN} state_t;

    state_t      state_reg;
    logic [4:0]  cnt_reg;
    logic [31:0] shift_reg;
    logic [7:0]  addr_reg;
    logic [1:0]  len_reg;
    logic        msb_reg, fill_reg, low_reg, end_reg;

    // In IDLE the incoming bit is frame bit 0, so the live cfg inputs apply;
    // afterwards the values captured on bit 0 are used.
    logic        is_idle;
    logic [1:0]  len_cur;
    logic        msb_cur, fill_cur, low_cur, end_cur;
    assign is_idle  = (state_reg == IDLE);
    assign len_cur  = is_idle ? cfg_length : len_reg;
    assign msb_cur  = is_idle ? cfg_msb    : msb_reg;
    assign fill_cur = is_idle ? cfg_fill   : fill_reg;
    assign low_cur  = is_idle ? cfg_low    : low_reg;
    assign end_cur  = is_idle ? cfg_end    : end_reg;

    logic [31:0] shift_next;
    assign shift_next = {shift_reg[30:0], si_data};

    // Index of the last bit of a frame is 8*(len+1)-1 = {len, 3'b111}.
    logic last_bit;
    assign last_bit = (cnt_reg == {len_cur, 3'b111});

    // Bit-reversed views of the shift register over each frame length.
    logic [31:0] rev32;
    logic [23:0] rev24;
    logic [15:0] rev16;
    logic [7:0]  rev8;
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rev
            assign rev32[gi] = shift_next[31-gi];
            if (gi < 24) begin : g24
                assign rev24[gi] = shift_next[23-gi];
            end
            if (gi < 16) begin : g16
                assign rev16[gi] = shift_next[15-gi];
            end
            if (gi < 8) begin : g8
                assign rev8[gi] = shift_next[7-gi];
            end
        end
    endgenerate

    // Frame value F (zero above bit N-1), the extracted word and pad check.
    logic [31:0] frame;
    logic [15:0] po_word;
    logic        pad_any;
    always_comb begin
        frame   = 32'h0;
        po_word = 16'h0;
        pad_any = 1'b0;
        case (len_cur)
            2'd0: frame = msb_cur ? {24'h0, shift_next[7:0]}  : {24'h0, rev8};
            2'd1: frame = msb_cur ? {16'h0, shift_next[15:0]} : {16'h0, rev16};
            2'd2: frame = msb_cur ? {8'h0, shift_next[23:0]}  : {8'h0, rev24};
            default: frame = msb_cur ? shift_next : rev32;
        endcase
        case (len_cur)
            2'd0: po_word = low_cur ? {frame[7:0], 8'h00} : {8'h00, frame[7:0]};
            2'd1: po_word = frame[15:0];
            2'd2: begin
                po_word = fill_cur ? frame[23:8] : frame[15:0];
                pad_any = fill_cur ? (|frame[7:0]) : (|frame[23:16]);
            end
            default: begin
                po_word = fill_cur ? frame[31:16] : frame[15:0];
                pad_any = fill_cur ? (|frame[15:0]) : (|frame[31:16]);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= 5'd0;
            shift_reg  <= 32'h0;
            addr_reg   <= 8'h0;
            len_reg    <= 2'd0;
            msb_reg    <= 1'b0;
            fill_reg   <= 1'b0;
            low_reg    <= 1'b0;
            end_reg    <= 1'b0;
            po_data    <= 16'h0;
            po_valid   <= 1'b0;
            byte_data  <= 8'h0;
            byte_addr  <= 8'h0;
            byte_valid <= 1'b0;
            pad_err    <= 1'b0;
            frame_err  <= 1'b0;
            rx_finish  <= 1'b0;
        end else begin
            po_valid   <= 1'b0;
            byte_valid <= 1'b0;
            pad_err    <= 1'b0;
            frame_err  <= 1'b0;
            case (state_reg)
                IDLE, RECV: begin
                    if (si_valid) begin
                        if (is_idle) begin
                            len_reg  <= cfg_length;
                            msb_reg  <= cfg_msb;
                            fill_reg <= cfg_fill;
                            low_reg  <= cfg_low;
                            end_reg  <= cfg_end;
                        end
                        shift_reg <= shift_next;
                        // Every 8th bit completes a byte.
                        if (cnt_reg[2:0] == 3'b111) begin
                            byte_data  <= shift_next[7:0];
                            byte_addr  <= addr_reg;
                            byte_valid <= 1'b1;
                            addr_reg   <= addr_reg + 8'd1;
                        end
                        if (last_bit) begin
                            po_data  <= po_word;
                            po_valid <= 1'b1;
                            pad_err  <= pad_any;
                            cnt_reg  <= 5'd0;
                            if (end_cur) begin
                                state_reg <= FIN;
                                rx_finish <= 1'b1;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            cnt_reg   <= cnt_reg + 5'd1;
                            state_reg <= RECV;
                        end
                    end else if (state_reg == RECV) begin
                        // Gap inside a frame: drop it, keep emitted bytes.
                        frame_err <= 1'b1;
                        cnt_reg   <= 5'd0;
                        state_reg <= IDLE;
                    end
                end
                default: ;  // FIN: only reset leaves
            endcase
        end
    end

endmodule
